// File: rtl/scr1_mem_arb2.sv
// Shares one memory bridge port between the SCR1 imem and dmem requesters with in-order response steering.
// Optional round-robin arbitration is enabled by defining SCR1_MEM_ARB_RR_EN (default: dmem fixed priority).
module scr1_mem_arb2 #(
    parameter int SCR1_ARB_OUTSTANDING = 2,
    parameter int SCR1_ADDR_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // imem requester
    input  logic                       imem_req,
    output logic                       imem_req_ack,
    input  logic [SCR1_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_rdata,
    output logic [1:0]                 imem_resp,
    // dmem requester
    input  logic                       dmem_req,
    output logic                       dmem_req_ack,
    input  logic                       dmem_cmd,
    input  logic [1:0]                 dmem_width,
    input  logic [SCR1_ADDR_WIDTH-1:0] dmem_addr,
    input  logic [31:0]                dmem_wdata,
    output logic [31:0]                dmem_rdata,
    output logic [1:0]                 dmem_resp,
    // bridge side
    output logic                       bus_req,
    input  logic                       bus_req_ack,
    output logic                       bus_cmd,
    output logic [1:0]                 bus_width,
    output logic [SCR1_ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]                bus_wdata,
    input  logic [31:0]                bus_rdata,
    input  logic [1:0]                 bus_resp,
    // status
    output logic                       arb_idle,
    output logic                       arb_err
);

    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic       CMD_RD      = 1'b0;
    localparam logic [1:0] WIDTH_WORD  = 2'b10;
    localparam int PTR_W = (SCR1_ARB_OUTSTANDING > 1) ? $clog2(SCR1_ARB_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(SCR1_ARB_OUTSTANDING) + 1;

    logic [SCR1_ARB_OUTSTANDING-1:0] tag_fifo;
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                cnt;
    logic full, empty, grant_dmem, push, pop, resp_vld, head;

    assign full  = (cnt == CNT_W'(SCR1_ARB_OUTSTANDING));
    assign empty = (cnt == '0);

`ifdef SCR1_MEM_ARB_RR_EN
    logic last_owner;  // 0 = imem, 1 = dmem
    // On contention the side that did not win last time gets the bus.
    assign grant_dmem = dmem_req & (~imem_req | ~last_owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last_owner <= 1'b0;
        else if (push) last_owner <= grant_dmem;
    end
`else
    assign grant_dmem = dmem_req;
`endif

    // Request path: purely combinational from the req inputs and registered state.
    assign bus_req      = (imem_req | dmem_req) & ~full;
    assign bus_cmd      = grant_dmem ? dmem_cmd   : CMD_RD;
    assign bus_width    = grant_dmem ? dmem_width : WIDTH_WORD;
    assign bus_addr     = grant_dmem ? dmem_addr  : imem_addr;
    assign bus_wdata    = grant_dmem ? dmem_wdata : 32'h0;
    assign imem_req_ack = imem_req & ~grant_dmem & bus_req_ack & ~full;
    assign dmem_req_ack = grant_dmem & bus_req_ack & ~full;

    assign push     = bus_req & bus_req_ack;
    assign resp_vld = (bus_resp != RESP_NOTRDY);
    assign pop      = resp_vld & ~empty;
    assign head     = tag_fifo[rd_ptr];

    // Responses complete in issue order, so the FIFO head names the owner.
    assign imem_resp  = (pop & ~head) ? bus_resp  : RESP_NOTRDY;
    assign imem_rdata = (pop & ~head) ? bus_rdata : 32'h0;
    assign dmem_resp  = (pop &  head) ? bus_resp  : RESP_NOTRDY;
    assign dmem_rdata = (pop &  head) ? bus_rdata : 32'h0;
    assign arb_idle   = empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_fifo <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            arb_err  <= 1'b0;
        end else begin
            if (push) begin
                tag_fifo[wr_ptr] <= grant_dmem;
                wr_ptr <= (wr_ptr == PTR_W'(SCR1_ARB_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(SCR1_ARB_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
            // A response with nothing outstanding is unrecoverable until reset.
            if (resp_vld && empty) arb_err <= 1'b1;
        end
    end

endmodule

// File: doc/scr1_mem_arb2.md
# scr1_mem_arb2

Two-requester arbiter that shares one memory core-interface port (a single memory AXI bridge) between the instruction-memory and data-memory requesters of the SCR1 core. Requests are forwarded with no added latency. Each accepted request's owner is recorded in an in-order tag FIFO, so responses from the bridge, which complete strictly in issue order, are steered back to the correct requester. Sits between the core's imem/dmem ports and the memory AXI bridge.

## Interface
- SCR1_ARB_OUTSTANDING, 2, tag FIFO depth; power of 2; must be ≥ the bridge request buffer depth
- SCR1_ADDR_WIDTH, 32, address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- imem_req / imem_req_ack  in / out  1  imem request / acceptance
- imem_addr  in  SCR1_ADDR_WIDTH  imem address; imem is always a word read
- imem_rdata / imem_resp  out  32 / 2  imem read data / response (type_scr1_mem_resp_e)
- dmem_req / dmem_req_ack  in / out  1  dmem request / acceptance
- dmem_cmd / dmem_width  in  1 / 2  dmem command (type_scr1_mem_cmd_e) / access width (type_scr1_mem_width_e)
- dmem_addr / dmem_wdata  in  SCR1_ADDR_WIDTH / 32  dmem address / write data
- dmem_rdata / dmem_resp  out  32 / 2  dmem read data / response
- bus_req / bus_req_ack  out / in  1  request to bridge / acceptance from bridge
- bus_cmd, bus_width, bus_addr, bus_wdata  out  1, 2, SCR1_ADDR_WIDTH, 32  request fields of the granted requester
- bus_rdata / bus_resp  in  32 / 2  bridge response data / response
- arb_idle  out  1  tag FIFO empty (no response pending)
- arb_err  out  1  sticky flag: a response arrived with the tag FIFO empty

## Operation
- **Full signal:** `full` is computed from the registered count only (`cnt == SCR1_ARB_OUTSTANDING`). A pop in the same cycle does not allow a push (no bypass).
- **Grant (combinational):**
  - If only one requester is active, it is granted.
  - If both are active, the winner is chosen per the Configuration section.
  - `bus_req = (imem_req | dmem_req) & ~full`.
- **Request fields:** bus_* fields are muxed from the granted requester. When imem is granted: `bus_cmd = RD`, `bus_width = WORD`, `bus_wdata = 0`.
- **Acceptance:**
  - `<granted>_req_ack = bus_req_ack & ~full`.
  - The non-granted requester's ack is 0.
  - Push the owner bit (0 = imem, 1 = dmem) into the tag FIFO on `bus_req & bus_req_ack`.
- **Response routing:**
  - On `bus_resp != NOTRDY` with the FIFO non-empty: pop the head and drive the owner's `resp = bus_resp` and `rdata = bus_rdata`.
  - The other requester sees `NOTRDY` and `rdata = 0`.
- **Response with FIFO empty:** the response is dropped, both requesters see NOTRDY, and `arb_err` is set; it stays set until reset.
- **Simultaneous push and pop:** the count is unchanged, and both pointers advance modulo SCR1_ARB_OUTSTANDING.
- **State:** tag FIFO (SCR1_ARB_OUTSTANDING × 1 bit), write/read pointers, count (`$clog2(SCR1_ARB_OUTSTANDING)+1` bits), `last_owner`, `arb_err`.
- **Reset values:** count/pointers 0, `last_owner` = imem, `arb_err` 0.
- **Outputs during reset:**
  - `bus_req` is 0 only when neither requester is active. It is not otherwise forced; full = 0 after reset.
  - All `*_resp` are NOTRDY unless bus_resp is valid, and even then they are NOTRDY because the FIFO is empty.
  - `arb_idle` = 1.
- **Reset mid-operation:** the FIFO is cleared, and any in-flight responses that arrive afterwards set `arb_err`.

## Timing
- Request path is zero-cycle: requester → bus_* within the same cycle. Ack path is also combinational.
- Response path is zero-cycle: bus_resp/bus_rdata → owner within the same cycle.
- No combinational path from bus_req_ack to grant selection. Grant depends only on the req inputs, `last_owner` and `full`.
- Grant is stable while inputs are stable: `last_owner` changes only on an accepted request.
- Throughput is one accepted request per cycle while not full.

## Configuration
- **SCR1_MEM_ARB_RR_EN defined:** round-robin. On contention the requester other than `last_owner` wins. `last_owner` updates to the owner on each acceptance.
- **SCR1_MEM_ARB_RR_EN undefined:** fixed priority, dmem always wins on contention. `last_owner` is unused.

## Test plan
- **Single imem read:** imem_req with addr 0x100, bridge acks at once and returns RDY_OK with rdata 0xDEADBEEF 2 cycles later → imem_resp = RDY_OK with rdata 0xDEADBEEF in that cycle; dmem_resp stays NOTRDY; arb_idle returns to 1.
- **Contention:** both req held for 4 cycles with continuous ack.
  - RR build → grants in order dmem, imem, dmem, imem.
  - Non-RR build → dmem, dmem, dmem, dmem.
- **Full:** SCR1_ARB_OUTSTANDING = 2, two requests acked with no responses → third cycle has bus_req = 0 and both acks 0. In the cycle the first response arrives, the push is still blocked. The next cycle accepts.
- **Out-of-owner ordering:** issue imem, dmem, imem back to back; return responses with rdata 1, 2, 3 → imem gets 1, dmem gets 2, imem gets 3.
- **Spurious response:** bus_resp = RDY_ER while idle → both resps NOTRDY; arb_err = 1 and it stays set until rst_n is asserted.
- **Reset mid-flight:** assert rst_n low with 2 outstanding → count 0 and arb_idle = 1 immediately (asynchronous).
